// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM/WB slice: write-back select, access size,
// exception codes and the MEM-stage FSM state.
package cpu_pkg;

  localparam logic [1:0] WDIN_ALU  = 2'b00;
  localparam logic [1:0] WDIN_LOAD = 2'b01;
  localparam logic [1:0] WDIN_PC4  = 2'b10;
  localparam logic [1:0] WDIN_EXT  = 2'b11;

  localparam logic [2:0] SZ_W  = 3'b000;
  localparam logic [2:0] SZ_BS = 3'b001;
  localparam logic [2:0] SZ_BU = 3'b010;
  localparam logic [2:0] SZ_HS = 3'b011;
  localparam logic [2:0] SZ_HU = 3'b100;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half lane from a read word and extends it.
// Purely combinational, zero latency, no flow control.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BS:   o_data = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_data = {24'd0, w_byte};
      SZ_HS:   o_data = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage + MEM/WB register: issues loads/stores on a req/ack bus, stalls upstream
// until ack or timeout (minimum 2 stall cycles), then registers the write-back result.
module mem_access_wb
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] mem_aluc,
  input  logic [31:0] mem_rd2,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_ext,
  input  logic        mem_dram_we,
  input  logic [1:0]  mem_wdin_sel,
  input  logic        mem_rf_we,
  input  logic [2:0]  mem_wd_sel,
  input  logic        mem_have_inst,
  input  logic [4:0]  mem_wr,
  input  logic [31:0] mem_pc,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic        stall_o,
  output logic [31:0] wb_wd,
  output logic [4:0]  wb_wr,
  output logic        wb_rf_we,
  output logic        wb_have_inst,
  output logic [31:0] wb_pc,
  output logic [1:0]  wb_exc
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  logic        w_acc, w_is_byte, w_is_half, w_mis_addr, w_mis, w_go, w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load, w_wd;
  logic [1:0]  w_exc;

  assign w_acc      = mem_have_inst & (mem_dram_we | (mem_wdin_sel == WDIN_LOAD));
  assign w_is_byte  = (mem_wd_sel == SZ_BS) | (mem_wd_sel == SZ_BU);
  assign w_is_half  = (mem_wd_sel == SZ_HS) | (mem_wd_sel == SZ_HU);
  assign w_mis_addr = w_is_half ? mem_aluc[0] : (~w_is_byte & (mem_aluc[1:0] != 2'b00));
  assign w_mis      = w_acc & w_mis_addr;
  assign w_go       = w_acc & ~w_mis_addr;
  assign stall_o    = w_go & (r_state != ST_DONE);
  // r_err is only meaningful for the instruction completing in DONE
  assign w_err      = (r_state == ST_DONE) & r_err;

  always_comb begin
    if (w_is_byte) begin
      w_be    = 4'b0001 << mem_aluc[1:0];
      w_wdata = {4{mem_rd2[7:0]}};
    end else if (w_is_half) begin
      w_be    = mem_aluc[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{mem_rd2[15:0]}};
    end else begin
      w_be    = 4'b1111;
      w_wdata = mem_rd2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_REQ;
            r_cnt   <= 8'd0;
            r_req   <= 1'b1;
            r_we    <= mem_dram_we;
            r_addr  <= {mem_aluc[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
          end
        end
        ST_REQ: begin
          if (dm_ack_i || (r_cnt == CNT_LAST)) begin
            r_state <= ST_DONE;
            r_err   <= ~dm_ack_i;
            r_rdata <= dm_ack_i ? dm_rdata_i : 32'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dm_req_o   = r_req;
  assign dm_we_o    = r_we;
  assign dm_addr_o  = r_addr;
  assign dm_be_o    = r_be;
  assign dm_wdata_o = r_wdata;

  load_align u_load_align (
    .i_rdata (r_rdata),
    .i_addr  (mem_aluc[1:0]),
    .i_size  (mem_wd_sel),
    .o_data  (w_load)
  );

  always_comb begin
    case (mem_wdin_sel)
      WDIN_LOAD: w_wd = w_load;
      WDIN_PC4:  w_wd = mem_pc4;
      WDIN_EXT:  w_wd = mem_ext;
      default:   w_wd = mem_aluc;
    endcase
  end

  assign w_exc = w_mis ? EXC_ALIGN : (w_err ? EXC_BUS : EXC_NONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_wd        <= 32'd0;
      wb_wr        <= 5'd0;
      wb_rf_we     <= 1'b0;
      wb_have_inst <= 1'b0;
      wb_pc        <= 32'd0;
      wb_exc       <= EXC_NONE;
    end else if (stall_o) begin
      wb_have_inst <= 1'b0;
      wb_rf_we     <= 1'b0;
      wb_exc       <= EXC_NONE;
    end else begin
      wb_wd        <= w_wd;
      wb_wr        <= mem_wr;
      wb_rf_we     <= mem_rf_we & ~w_mis & ~w_err;
      wb_have_inst <= mem_have_inst;
      wb_pc        <= mem_pc;
      wb_exc       <= w_exc;
    end
  end

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb with a short bus timeout.
module tb_mem_access_wb;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] mem_aluc = '0, mem_rd2 = '0, mem_pc4 = '0, mem_ext = '0, mem_pc = '0;
  logic        mem_dram_we = 1'b0, mem_rf_we = 1'b0, mem_have_inst = 1'b0;
  logic [1:0]  mem_wdin_sel = '0;
  logic [2:0]  mem_wd_sel = '0;
  logic [4:0]  mem_wr = '0;
  logic        dm_ack_i = 1'b0;
  logic [31:0] dm_rdata_i = '0;
  logic        dm_req_o, dm_we_o, stall_o, wb_rf_we, wb_have_inst;
  logic [31:0] dm_addr_o, dm_wdata_o, wb_wd, wb_pc;
  logic [3:0]  dm_be_o;
  logic [4:0]  wb_wr;
  logic [1:0]  wb_exc;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_access_wb #(.TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_aluc(mem_aluc), .mem_rd2(mem_rd2), .mem_pc4(mem_pc4), .mem_ext(mem_ext),
    .mem_dram_we(mem_dram_we), .mem_wdin_sel(mem_wdin_sel), .mem_rf_we(mem_rf_we),
    .mem_wd_sel(mem_wd_sel), .mem_have_inst(mem_have_inst), .mem_wr(mem_wr),
    .mem_pc(mem_pc),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
    .dm_wdata_o(dm_wdata_o), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
    .stall_o(stall_o),
    .wb_wd(wb_wd), .wb_wr(wb_wr), .wb_rf_we(wb_rf_we), .wb_have_inst(wb_have_inst),
    .wb_pc(wb_pc), .wb_exc(wb_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_inst(input logic [31:0] aluc, input logic [1:0] wdin, input logic [2:0] sz,
                          input logic dwe, input logic rfwe, input logic [4:0] wr,
                          input logic [31:0] pc);
    mem_have_inst = 1'b1;
    mem_aluc      = aluc;
    mem_wdin_sel  = wdin;
    mem_wd_sel    = sz;
    mem_dram_we   = dwe;
    mem_rf_we     = rfwe;
    mem_wr        = wr;
    mem_pc        = pc;
  endtask

  // Aligned load acked in the first REQ cycle; checks the formatted result.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] sz,
                         input logic [31:0] rdata, input logic [3:0] be,
                         input logic [31:0] exp);
    set_inst(addr, 2'b01, sz, 1'b0, 1'b1, 5'd7, 32'h100);
    #1;
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "_idle_req"}, 32'(dm_req_o), 32'd0);
    tick();
    chk({tag, "_bubble1"}, 32'(wb_have_inst), 32'd0);
    chk({tag, "_req"}, 32'(dm_req_o), 32'd1);
    chk({tag, "_addr"}, dm_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_be"}, 32'(dm_be_o), 32'(be));
    chk({tag, "_req_stall"}, 32'(stall_o), 32'd1);
    dm_ack_i   = 1'b1;
    dm_rdata_i = rdata;
    tick();
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done_req"}, 32'(dm_req_o), 32'd0);
    chk({tag, "_bubble2"}, 32'(wb_have_inst), 32'd0);
    tick();
    chk({tag, "_wd"}, wb_wd, exp);
    chk({tag, "_have"}, 32'(wb_have_inst), 32'd1);
    chk({tag, "_rfwe"}, 32'(wb_rf_we), 32'd1);
    chk({tag, "_exc"}, 32'(wb_exc), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_wb_wd", wb_wd, 32'd0);
    chk("rst_wb_have", 32'(wb_have_inst), 32'd0);
    chk("rst_wb_exc", 32'(wb_exc), 32'd0);
    chk("rst_req", 32'(dm_req_o), 32'd0);
    #5 rst_n_i = 1'b1;
    tick();

    // ALU pass-through
    set_inst(32'h1234, 2'b00, 3'b000, 1'b0, 1'b1, 5'd5, 32'h10);
    #1;
    chk("alu_stall", 32'(stall_o), 32'd0);
    chk("alu_req", 32'(dm_req_o), 32'd0);
    tick();
    chk("alu_wd", wb_wd, 32'h1234);
    chk("alu_wr", 32'(wb_wr), 32'd5);
    chk("alu_rfwe", 32'(wb_rf_we), 32'd1);
    chk("alu_have", 32'(wb_have_inst), 32'd1);
    chk("alu_pc", wb_pc, 32'h10);

    // jal link and lui
    set_inst(32'h9999, 2'b10, 3'b000, 1'b0, 1'b1, 5'd31, 32'h40);
    mem_pc4 = 32'h44;
    tick();
    chk("pc4_wd", wb_wd, 32'h44);
    set_inst(32'h9999, 2'b11, 3'b000, 1'b0, 1'b1, 5'd3, 32'h48);
    mem_ext = 32'hABC0_0000;
    tick();
    chk("ext_wd", wb_wd, 32'hABC0_0000);

    // Loads of each size
    do_load("lb", 32'h103, 3'b001, 32'h80FF_FF7F, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 32'h001, 3'b010, 32'h0000_A500, 4'b0010, 32'h0000_00A5);
    do_load("lhu", 32'h102, 3'b100, 32'h8765_4321, 4'b1100, 32'h0000_8765);
    do_load("lh", 32'h200, 3'b011, 32'h1234_F00D, 4'b0011, 32'hFFFF_F00D);

    // sh at 0x102, ack in third REQ cycle
    set_inst(32'h102, 2'b00, 3'b011, 1'b1, 1'b0, 5'd0, 32'h60);
    mem_rd2 = 32'h0000_ABCD;
    #1;
    chk("sh_idle_stall", 32'(stall_o), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(dm_req_o), 32'd1);
      chk("sh_we", 32'(dm_we_o), 32'd1);
      chk("sh_addr", dm_addr_o, 32'h100);
      chk("sh_be", 32'(dm_be_o), 32'b1100);
      chk("sh_wdata", dm_wdata_o, 32'hABCD_ABCD);
      chk("sh_stall", 32'(stall_o), 32'd1);
      if (i == 2) dm_ack_i = 1'b1;
      tick();
    end
    dm_ack_i = 1'b0;
    chk("sh_done_req", 32'(dm_req_o), 32'd0);
    chk("sh_done_stall", 32'(stall_o), 32'd0);
    tick();
    chk("sh_have", 32'(wb_have_inst), 32'd1);
    chk("sh_rfwe", 32'(wb_rf_we), 32'd0);
    chk("sh_wd", wb_wd, 32'h102);

    // Misaligned lw: no request, no stall
    set_inst(32'h101, 2'b01, 3'b000, 1'b0, 1'b1, 5'd8, 32'h70);
    #1;
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_req", 32'(dm_req_o), 32'd0);
    tick();
    chk("mis_exc", 32'(wb_exc), 32'd1);
    chk("mis_rfwe", 32'(wb_rf_we), 32'd0);
    chk("mis_have", 32'(wb_have_inst), 32'd1);
    chk("mis_req_after", 32'(dm_req_o), 32'd0);

    // lw with no ack: 4 REQ cycles then bus error
    set_inst(32'h200, 2'b01, 3'b000, 1'b0, 1'b1, 5'd9, 32'h50);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(dm_req_o), 32'd1);
      tick();
    end
    chk("to_done_req", 32'(dm_req_o), 32'd0);
    chk("to_done_stall", 32'(stall_o), 32'd0);
    tick();
    chk("to_exc", 32'(wb_exc), 32'd2);
    chk("to_wd", wb_wd, 32'd0);
    chk("to_rfwe", 32'(wb_rf_we), 32'd0);
    chk("to_have", 32'(wb_have_inst), 32'd1);

    // Reset during REQ, then the held access re-issues
    set_inst(32'h300, 2'b01, 3'b000, 1'b0, 1'b1, 5'd10, 32'h80);
    tick();
    chk("rr_req", 32'(dm_req_o), 32'd1);
    chk("rr_held_pc", wb_pc, 32'h50);
    #1 rst_n_i = 1'b0;
    #1;
    chk("rr_req_drop", 32'(dm_req_o), 32'd0);
    chk("rr_wb_pc", wb_pc, 32'd0);
    chk("rr_wb_wr", 32'(wb_wr), 32'd0);
    chk("rr_wb_exc", 32'(wb_exc), 32'd0);
    #2 rst_n_i = 1'b1;
    #1;
    chk("rr_idle_stall", 32'(stall_o), 32'd1);
    chk("rr_idle_req", 32'(dm_req_o), 32'd0);
    tick();
    chk("rr_reissue_req", 32'(dm_req_o), 32'd1);
    chk("rr_reissue_addr", dm_addr_o, 32'h300);
    dm_ack_i   = 1'b1;
    dm_rdata_i = 32'h1122_3344;
    tick();
    dm_ack_i = 1'b0;
    chk("rr_done_stall", 32'(stall_o), 32'd0);
    tick();
    chk("rr_wd", wb_wd, 32'h1122_3344);
    chk("rr_exc", 32'(wb_exc), 32'd0);
    chk("rr_rfwe", 32'(wb_rf_we), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_wb.md
Name: mem_access_wb

Overview:
- MEM stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs (mem_*) and performs load/store on a handshaked data-memory bus.
- It formats load data, selects write-back data and registers the result toward WB.
- stall_o tells the hazard unit to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- TIMEOUT_CYC, 16: cycles spent in REQ without dm_ack_i before the access is aborted as a bus error (range 1..255).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- mem_aluc  in  32  ALU result; data address for load/store.
- mem_rd2  in  32  store data.
- mem_pc4  in  32  PC+4 (link write-back).
- mem_ext  in  32  extended immediate (lui write-back).
- mem_dram_we  in  1  store.
- mem_wdin_sel  in  2  write-back select: 00 aluc, 01 load, 10 pc4, 11 ext.
- mem_rf_we  in  1  regfile write enable.
- mem_wd_sel  in  3  access size: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; others treated as word.
- mem_have_inst  in  1  valid instruction in MEM.
- mem_wr  in  5  destination register.
- mem_pc  in  32  instruction PC.
- dm_req_o  out  1  bus request.
- dm_we_o  out  1  bus write.
- dm_addr_o  out  32  word-aligned address ({mem_aluc[31:2],2'b00}).
- dm_be_o  out  4  byte enables.
- dm_wdata_o  out  32  lane-replicated store data.
- dm_ack_i  in  1  access complete; rdata valid this cycle.
- dm_rdata_i  in  32  read word.
- stall_o  out  1  freeze upstream.
- wb_wd  out  32  write-back data.
- wb_wr  out  5  destination register.
- wb_rf_we  out  1  write enable.
- wb_have_inst  out  1  valid.
- wb_pc  out  32  PC.
- wb_exc  out  2  00 none, 01 misaligned, 10 bus timeout.

Behaviour:
- acc = mem_have_inst & (mem_dram_we | mem_wdin_sel==01).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. A misaligned access never issues a bus request.
- FSM states IDLE, REQ, DONE. Reset state is IDLE.
  - IDLE: acc & aligned goes to REQ. Otherwise stay in IDLE; the instruction passes with zero stall.
  - REQ: dm_req_o=1. dm_ack_i goes to DONE and latches rdata. When the timeout counter reaches TIMEOUT_CYC-1 without ack, go to DONE with the err flag set and rdata=0.
  - DONE: always goes to IDLE.
- In REQ, dm_req_o, dm_we_o, dm_addr_o, dm_be_o and dm_wdata_o are held stable until the ack cycle. In all other states they are 0.
- Timeout counter clears on entry to REQ and increments each REQ cycle.
- stall_o = acc & aligned & (state != DONE). It is combinational, so the minimum memory-op stall is 2 cycles (IDLE and REQ with ack in the first REQ cycle).
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- dm_wdata_o replicates the low byte or half across lanes.
- Load format: select the lane by addr[1:0], then sign- or zero-extend per mem_wd_sel.
- MEM/WB register (posedge clk_i or negedge rst_n_i): all wb_* outputs reset to 0.
  - While stall_o=1, the register loads a bubble: have_inst=0, rf_we=0, exc=00, other fields don't-care (hold).
  - Otherwise it loads have_inst, wr, pc and wd from the wdin_sel mux.
  - wb_rf_we is mem_rf_we & ~misaligned & ~err.
  - wb_exc is set accordingly.
- A store with mem_rf_we=1 still writes the regfile per wdin_sel. This is not an error.
- dm_ack_i outside REQ is ignored.
- Asynchronous reset mid-access: state goes to IDLE and dm_req_o drops immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package cpu_pkg holds:
  - WDIN_ALU/LOAD/PC4/EXT encodings.
  - SZ_W/SZ_BS/SZ_BU/SZ_HS/SZ_HU encodings.
  - EXC_NONE/EXC_ALIGN/EXC_BUS encodings.
  - The FSM state enum.
- One sub-module, load_align: combinational lane select and extension from rdata, addr[1:0] and size, reused by future cache logic.

Test Plan:
- ALU op, mem_wdin_sel=00, mem_aluc=0x1234, wr=5, rf_we=1 -> stall_o never asserts; next edge wb_wd=0x1234, wb_wr=5, wb_rf_we=1, wb_have_inst=1.
- lb at addr 0x103, rdata=0x80FF_FF7F, ack in the 1st REQ cycle -> 2 stall cycles; wb_wd=0xFFFF_FF80; the two preceding WB cycles are bubbles.
- sh at 0x102, rd2=0x0000_ABCD, ack after 3 REQ cycles -> req stable for 3 cycles; be=1100, wdata=0xABCD_ABCD, we=1.
- lw at 0x101 -> no dm_req_o, no stall; wb_exc=01, wb_rf_we=0, wb_have_inst=1.
- lw with ack never asserted, TIMEOUT_CYC=4 -> req high exactly 4 cycles; wb_exc=10, wb_wd=0, wb_rf_we=0.
- Assert rst_n_i low during REQ -> dm_req_o=0 and all wb_*=0 in the same cycle; after release the FSM is in IDLE and re-issues the held EX/MEM access.
